clk_div_multi: RTL and testbench

- Multi-channel programmable clock/strobe generator; next generation of the team's single-channel divider.
- Each of NUM_CH channels independently produces:
  - a divided clock with programmable period and high time (duty cycle);
  - a one-cycle frame-start tick.
- Period and high-time changes apply only at frame boundaries, so outputs never glitch.
- Feeds timing strobes (display refresh, debounce sampling, game tick) to downstream logic in the same clock domain.

---
 rtl/clk_div_multi_if.sv | 34 +++
 rtl/clk_div_multi.sv | 93 +++++++++
 tb/tb_clk_div_multi.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/clk_div_multi_if.sv
// Control and output bundle for the multi-channel clock/strobe generator.
// The master side programs enables, restarts and per-channel period/high
// fields; the slave side (the generator) returns divided clocks and ticks.
interface clk_div_multi_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 32
) ();

    logic [NUM_CH-1:0]       en;
    logic [NUM_CH-1:0]       restart;
    logic [NUM_CH*WIDTH-1:0] period;
    logic [NUM_CH*WIDTH-1:0] high;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;

    modport master (
        output en,
        output restart,
        output period,
        output high,
        input  clk_out,
        input  tick
    );

    modport slave (
        input  en,
        input  restart,
        input  period,
        input  high,
        output clk_out,
        output tick
    );

endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock/strobe generator.
// Each channel runs a frame counter against shadowed period/high values that
// are only reloaded while idle, on restart, or at the frame wrap, so a
// reprogrammed channel never emits a truncated or stretched pulse.
module clk_div_multi #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned WIDTH  = 32
) (
    input  logic            clk_in,
    input  logic            rst_n,
    clk_div_multi_if.slave  bus
);

    // Per-channel frame state
    logic [WIDTH-1:0] cnt_q     [NUM_CH];
    logic [WIDTH-1:0] cnt_d     [NUM_CH];
    logic [WIDTH-1:0] p_s_q     [NUM_CH];
    logic [WIDTH-1:0] p_s_d     [NUM_CH];
    logic [WIDTH-1:0] h_s_q     [NUM_CH];
    logic [WIDTH-1:0] h_s_d     [NUM_CH];
    logic [NUM_CH-1:0] clk_out_q;
    logic [NUM_CH-1:0] clk_out_d;
    logic [NUM_CH-1:0] tick_q;
    logic [NUM_CH-1:0] tick_d;

    // Unpacked views of the inputs and the per-channel wrap value
    logic [WIDTH-1:0] period_in [NUM_CH];
    logic [WIDTH-1:0] high_in   [NUM_CH];
    logic [WIDTH-1:0] last_cnt  [NUM_CH];

    // Unpack the packed fields; a shadow period of 0 behaves as period 1,
    // so both wrap at count 0.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            period_in[i] = bus.period[i*WIDTH +: WIDTH];
            high_in[i]   = bus.high[i*WIDTH +: WIDTH];
            last_cnt[i]  = (p_s_q[i] == '0) ? '0 : p_s_q[i] - WIDTH'(1);
        end
    end

    // Next-state: idle/restart park the channel and track the inputs; running
    // channels emit outputs from the pre-edge count and reload at the wrap.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]     = cnt_q[i];
            p_s_d[i]     = p_s_q[i];
            h_s_d[i]     = h_s_q[i];
            clk_out_d[i] = 1'b0;
            tick_d[i]    = 1'b0;

            if (!bus.en[i] || bus.restart[i]) begin
                cnt_d[i] = '0;
                p_s_d[i] = period_in[i];
                h_s_d[i] = high_in[i];
            end else begin
                tick_d[i]    = (cnt_q[i] == '0);
                clk_out_d[i] = (cnt_q[i] < h_s_q[i]);
                if (cnt_q[i] == last_cnt[i]) begin
                    cnt_d[i] = '0;
                    p_s_d[i] = period_in[i];
                    h_s_d[i] = high_in[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + WIDTH'(1);
                end
            end
        end
    end

    // State registers with asynchronous clear of every channel
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                p_s_q[i] <= '0;
                h_s_q[i] <= '0;
            end
            clk_out_q <= '0;
            tick_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
                p_s_q[i] <= p_s_d[i];
                h_s_q[i] <= h_s_d[i];
            end
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign bus.clk_out = clk_out_q;
    assign bus.tick    = tick_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: expected per-edge clk_out/tick patterns
// are written out as strings, one character per rising edge.
module tb_clk_div_multi;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned WIDTH  = 32;

    logic clk_in;
    logic rst_n;

    clk_div_multi_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bif ();

    clk_div_multi #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .bus    (bif)
    );

    int n_vec;
    int n_err;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_ch(input int ch, input logic [31:0] p, input logic [31:0] h);
        bif.period[ch*WIDTH +: WIDTH] = p;
        bif.high[ch*WIDTH +: WIDTH]   = h;
    endtask

    // Park all channels for one edge (shadows track inputs), then enable mask.
    task automatic start(input logic [NUM_CH-1:0] mask);
        bif.en = '0;
        @(posedge clk_in);
        #1;
        bif.en = mask;
    endtask

    // Step edges; channels a and b follow the pattern strings, others must be 0.
    task automatic run2(input string tag, input int a, input int b,
                        input string ca, input string ta,
                        input string cb, input string tb);
        logic [31:0] exp_c;
        logic [31:0] exp_t;
        byte c;
        for (int i = 0; i < ca.len(); i++) begin
            exp_c = '0;
            exp_t = '0;
            c = ca[i]; exp_c[a] = (c == 8'h31);
            c = ta[i]; exp_t[a] = (c == 8'h31);
            c = cb[i]; exp_c[b] = (c == 8'h31);
            c = tb[i]; exp_t[b] = (c == 8'h31);
            @(posedge clk_in);
            #1;
            check($sformatf("%s_clk%0d", tag, i), 32'(bif.clk_out), exp_c);
            check($sformatf("%s_tick%0d", tag, i), 32'(bif.tick), exp_t);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bif.en      = '1;
        bif.restart = '0;
        bif.period  = '0;
        bif.high    = '0;
        for (int ch = 0; ch < int'(NUM_CH); ch++) load_ch(ch, 32'd4, 32'd2);

        // Outputs held low during reset even with channels enabled
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_clk", 32'(bif.clk_out), 32'h0);
        check("rst_tick", 32'(bif.tick), 32'h0);
        bif.en = '0;
        #3;
        rst_n = 1'b1;

        // Basic 4/2 frame on ch0
        load_ch(0, 32'd4, 32'd2);
        start(4'b0001);
        run2("basic", 0, 0, "11001100", "10001000", "11001100", "10001000");

        // Mid-frame reprogram: current 4/1 frame completes, then 6/3
        load_ch(0, 32'd4, 32'd1);
        start(4'b0001);
        run2("mf", 0, 0, "1", "1", "1", "1");
        load_ch(0, 32'd6, 32'd3);
        run2("mf2", 0, 0, "0001110001", "0001000001", "0001110001", "0001000001");

        // Boundary values
        load_ch(0, 32'd3, 32'd0);
        start(4'b0001);
        run2("h0", 0, 0, "000000", "100100", "000000", "100100");
        load_ch(0, 32'd5, 32'd7);
        start(4'b0001);
        run2("hbig", 0, 0, "111111", "100001", "111111", "100001");
        load_ch(0, 32'd0, 32'd1);
        start(4'b0001);
        run2("p0", 0, 0, "1111", "1111", "1111", "1111");
        load_ch(0, 32'd1, 32'd0);
        start(4'b0001);
        run2("p1", 0, 0, "0000", "1111", "0000", "1111");

        // Restart on ch1 at cnt=6 of a 10/5 frame
        load_ch(1, 32'd10, 32'd5);
        start(4'b0010);
        run2("rs", 1, 1, "111110", "100000", "111110", "100000");
        bif.restart[1] = 1'b1;
        run2("rs_pulse", 1, 1, "0", "0", "0", "0");
        bif.restart[1] = 1'b0;
        run2("rs_new", 1, 1, "11111000001", "10000000001", "11111000001", "10000000001");

        // Asynchronous reset mid-frame with two channels running
        load_ch(0, 32'd3, 32'd1);
        load_ch(1, 32'd8, 32'd4);
        start(4'b0011);
        run2("ar", 0, 1, "1001", "1001", "1111", "1000");
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_async_clk", 32'(bif.clk_out), 32'h0);
        check("ar_async_tick", 32'(bif.tick), 32'h0);
        @(posedge clk_in);
        #1;
        check("ar_hold_clk", 32'(bif.clk_out), 32'h0);
        check("ar_hold_tick", 32'(bif.tick), 32'h0);
        #2;
        rst_n = 1'b1;
        // Cleared shadows act as period 1 for one edge, then 3/1 and 8/4 load
        run2("ar_rel", 0, 1, "010010", "110010", "011110", "110000");

        // en dropped at cnt=2 of a 5/3 frame, then re-enabled
        load_ch(2, 32'd5, 32'd3);
        start(4'b0100);
        run2("ef", 2, 2, "11", "10", "11", "10");
        bif.en[2] = 1'b0;
        run2("ef_idle", 2, 2, "00", "00", "00", "00");
        bif.en[2] = 1'b1;
        run2("ef_re", 2, 2, "1110", "1000", "1110", "1000");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
